sargantana_icache_way_ctrl: RTL and testbench

//  Initiator for one icache way SRAM port (req/we/addr/data, 1-cycle read latency).

---
 rtl/sargantana_icache_way_ctrl.sv | 111 +++++++++++
 tb/tb_sargantana_icache_way_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_way_ctrl.sv
// Icache way SRAM port controller: collects refill beats into a full line, writes the line to the way,
// and interleaves lookup reads. A line write takes priority over a lookup.
module sargantana_icache_way_ctrl #(
    parameter int SET_WIDHT  = 256,
    parameter int ADDR_WIDHT = 6,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  lkp_req_i,
    input  logic [ADDR_WIDHT-1:0] lkp_addr_i,
    output logic                  lkp_gnt_o,
    output logic                  lkp_rvalid_o,
    output logic [SET_WIDHT-1:0]  lkp_rdata_o,
    input  logic                  fill_start_i,
    input  logic [ADDR_WIDHT-1:0] fill_addr_i,
    input  logic                  fill_abort_i,
    input  logic                  fill_valid_i,
    input  logic [BEAT_WIDTH-1:0] fill_data_i,
    output logic                  fill_ready_o,
    output logic                  fill_busy_o,
    output logic                  fill_done_o,
    output logic                  way_req_o,
    output logic                  way_we_o,
    output logic [ADDR_WIDHT-1:0] way_addr_o,
    output logic [SET_WIDHT-1:0]  way_data_o,
    input  logic [SET_WIDHT-1:0]  way_data_i
);

    localparam int N_BEATS = SET_WIDHT / BEAT_WIDTH;
    localparam int CNT_W   = $clog2(N_BEATS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [SET_WIDHT-1:0]  line_q, line_d;
    logic [ADDR_WIDHT-1:0] fill_addr_q, fill_addr_d;
    logic                  lkp_rvalid_q, lkp_rvalid_d;
    logic                  fill_done_q, fill_done_d;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        fill_addr_d = fill_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_start_i) begin
                    fill_addr_d = fill_addr_i;
                    beat_cnt_d  = '0;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Abort wins over a beat presented in the same cycle.
                if (fill_abort_i) begin
                    beat_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (fill_valid_i) begin
                    line_d[int'(beat_cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = fill_data_i;
                    if (beat_cnt_q == CNT_W'(N_BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign lkp_gnt_o    = lkp_req_i && (state_q != ST_WRITE);
    assign lkp_rvalid_d = lkp_gnt_o;
    assign fill_done_d  = (state_q == ST_WRITE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            fill_addr_q  <= '0;
            lkp_rvalid_q <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            line_q       <= line_d;
            fill_addr_q  <= fill_addr_d;
            lkp_rvalid_q <= lkp_rvalid_d;
            fill_done_q  <= fill_done_d;
        end
    end

    // The SRAM read data already carries the one-cycle latency, so it is passed straight through.
    assign lkp_rvalid_o = lkp_rvalid_q;
    assign lkp_rdata_o  = way_data_i;
    assign fill_ready_o = (state_q == ST_COLLECT);
    assign fill_busy_o  = (state_q != ST_IDLE);
    assign fill_done_o  = fill_done_q;

    assign way_we_o   = (state_q == ST_WRITE);
    assign way_req_o  = way_we_o || lkp_gnt_o;
    assign way_addr_o = way_we_o ? fill_addr_q : lkp_addr_i;
    assign way_data_o = line_q;

endmodule

// File: tb/tb_sargantana_icache_way_ctrl.sv
// Randomized bench for the icache way controller: a behavioural SRAM, a queue-based line model
// and a scoreboard that matches lookup responses in grant order.
module tb_sargantana_icache_way_ctrl;

    localparam int SW = 256;
    localparam int AW = 6;
    localparam int BW = 64;
    localparam int NB = SW / BW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          lkp_req = 1'b0;
    logic [AW-1:0] lkp_addr = '0;
    logic          lkp_gnt, lkp_rvalid;
    logic [SW-1:0] lkp_rdata;
    logic          fill_start = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic          fill_abort = 1'b0;
    logic          fill_valid = 1'b0;
    logic [BW-1:0] fill_data = '0;
    logic          fill_ready, fill_busy, fill_done;
    logic          way_req, way_we;
    logic [AW-1:0] way_addr;
    logic [SW-1:0] way_wdata;
    logic [SW-1:0] way_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    sargantana_icache_way_ctrl #(.SET_WIDHT(SW), .ADDR_WIDHT(AW), .BEAT_WIDTH(BW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .lkp_req_i(lkp_req), .lkp_addr_i(lkp_addr), .lkp_gnt_o(lkp_gnt),
        .lkp_rvalid_o(lkp_rvalid), .lkp_rdata_o(lkp_rdata),
        .fill_start_i(fill_start), .fill_addr_i(fill_addr), .fill_abort_i(fill_abort),
        .fill_valid_i(fill_valid), .fill_data_i(fill_data), .fill_ready_o(fill_ready),
        .fill_busy_o(fill_busy), .fill_done_o(fill_done),
        .way_req_o(way_req), .way_we_o(way_we), .way_addr_o(way_addr),
        .way_data_o(way_wdata), .way_data_i(way_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural way SRAM with one-cycle read latency
    logic [SW-1:0] sram [64];
    always @(posedge clk) begin
        if (way_req) begin
            if (way_we) sram[way_addr] <= way_wdata;
            else        way_rdata <= sram[way_addr];
        end
    end

    function automatic logic [SW-1:0] rand_line();
        logic [SW-1:0] r;
        for (int k = 0; k < SW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Reference model: contents of every set, plus the refill in flight as a list of beats
    logic [SW-1:0] ref_mem [64];
    logic [SW-1:0] exp_q [$];
    logic [BW-1:0] m_beats [$];
    bit            m_fill = 0, m_wr = 0, m_done = 0, m_rv = 0;
    logic [AW-1:0] m_addr = '0;
    logic [SW-1:0] m_line = '0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [SW-1:0] v;
            v = rand_line();
            sram[i] = v;
            ref_mem[i] = v;
        end
    end

    always @(negedge clk) begin
        bit exp_gnt, was_wr;
        if (!rstn) begin
            check("rst_rvalid", SW'(lkp_rvalid), '0);
            check("rst_done", SW'(fill_done), '0);
            check("rst_ready", SW'(fill_ready), '0);
            check("rst_busy", SW'(fill_busy), '0);
            check("rst_way_req", SW'(way_req), '0);
            check("rst_way_we", SW'(way_we), '0);
            m_fill = 0; m_wr = 0; m_done = 0; m_rv = 0;
            m_beats.delete();
            exp_q.delete();
        end else begin
            exp_gnt = lkp_req && !m_wr;
            check("lkp_gnt", SW'(lkp_gnt), SW'(exp_gnt));
            check("lkp_rvalid", SW'(lkp_rvalid), SW'(m_rv));
            check("fill_ready", SW'(fill_ready), SW'(m_fill));
            check("fill_busy", SW'(fill_busy), SW'(m_fill || m_wr));
            check("fill_done", SW'(fill_done), SW'(m_done));
            check("way_we", SW'(way_we), SW'(m_wr));
            check("way_req", SW'(way_req), SW'(m_wr || exp_gnt));
            if (m_wr) begin
                check("wr_addr", SW'(way_addr), SW'(m_addr));
                check("wr_data", way_wdata, m_line);
            end else if (exp_gnt) begin
                check("rd_addr", SW'(way_addr), SW'(lkp_addr));
                exp_q.push_back(ref_mem[lkp_addr]);
            end
            // Advance the model to what the coming clock edge does
            m_rv   = exp_gnt;
            m_done = m_wr;
            was_wr = m_wr;
            if (m_wr) begin
                ref_mem[m_addr] = m_line;
                m_wr = 0;
            end
            if (!m_fill && !was_wr) begin
                if (fill_start) begin
                    m_fill = 1;
                    m_addr = fill_addr;
                    m_beats.delete();
                end
            end else if (m_fill) begin
                if (fill_abort) begin
                    m_fill = 0;
                    m_beats.delete();
                end else if (fill_valid) begin
                    m_beats.push_back(fill_data);
                    if (m_beats.size() == NB) begin
                        for (int i = 0; i < NB; i++) m_line[i*BW +: BW] = m_beats[i];
                        m_fill = 0;
                        m_wr = 1;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: one response per grant, in grant order
    always @(negedge clk) begin
        if (rstn && lkp_rvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL lkp_unexpected: got rvalid expected none pending");
            end else begin
                check("lkp_rdata", lkp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_fill(input logic [AW-1:0] a, input logic [SW-1:0] line,
                           input int gap, input int abort_at, input int conflict_at);
        int t;
        @(posedge clk); #1;
        fill_start = 1'b1;
        fill_addr  = a;
        @(posedge clk); #1;
        fill_start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            fill_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            fill_valid = 1'b1;
            fill_data  = line[i*BW +: BW];
            if (i == abort_at) fill_abort = 1'b1;
            if (i == conflict_at) begin
                fill_start = 1'b1;
                fill_addr  = a ^ 6'h03;
            end
            t = 0;
            @(negedge clk);
            while (!fill_ready && t < 20) begin t++; @(negedge clk); end
            if (t >= 20) timeout("fill_ready_wait");
            @(posedge clk); #1;
            fill_valid = 1'b0;
            fill_abort = 1'b0;
            fill_start = 1'b0;
            $display("fill addr=%h beat=%0d data=%h abort=%0d", a, i, line[i*BW +: BW], i == abort_at);
            if (i == abort_at) break;
        end
    endtask

    task automatic do_lookups(input int n, input logic [AW-1:0] base, input int step, input bit rnd);
        int t;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            lkp_req  = 1'b1;
            lkp_addr = rnd ? AW'($urandom_range(63)) : AW'(int'(base) + i * step);
            t = 0;
            @(negedge clk);
            while (!lkp_gnt && t < 20) begin t++; @(negedge clk); end
            if (t >= 20) timeout("lkp_gnt_wait");
            $display("lookup addr=%h granted after %0d retries", lkp_addr, t);
            @(posedge clk); #1;
        end
        lkp_req = 1'b0;
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;

        // Reset in the middle of a refill after two beats
        @(posedge clk); #1;
        fill_start = 1'b1; fill_addr = 6'h0A;
        @(posedge clk); #1;
        fill_start = 1'b0; fill_valid = 1'b1; fill_data = 64'hAAAA_0000_0000_0001;
        @(posedge clk); #1;
        fill_data = 64'hAAAA_0000_0000_0002;
        @(posedge clk); #1;
        fill_valid = 1'b0;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        $display("reset mid-refill applied");
        do_fill(6'h0B, rand_line(), 0, -1, -1);

        // Known line to set 0x15, then read it back
        do_fill(6'h15, {64'h44, 64'h33, 64'h22, 64'h11}, 0, -1, -1);
        do_lookups(1, 6'h15, 0, 0);

        // Gapped beats
        do_fill(6'h16, rand_line(), 3, -1, -1);
        do_lookups(1, 6'h16, 0, 0);

        // Lookups held across the write cycle, then back-to-back 0x01, 0x02
        fork
            do_fill(6'h20, rand_line(), 0, -1, -1);
            do_lookups(12, 6'h20, 0, 0);
        join
        do_lookups(2, 6'h01, 1, 0);

        // Abort together with the final beat
        do_fill(6'h30, rand_line(), 0, 3, -1);
        do_lookups(1, 6'h30, 0, 0);

        // Second start while collecting is ignored
        do_fill(6'h31, rand_line(), 1, -1, 1);
        do_lookups(2, 6'h31, 3, 0);

        // Random concurrent refills and lookups
        for (int r = 0; r < 30; r++) begin
            int ab;
            ab = ($urandom_range(7) == 0) ? int'($urandom_range(NB - 1)) : -1;
            fork
                do_fill(AW'($urandom_range(63)), rand_line(), int'($urandom_range(2)), ab, -1);
                do_lookups(int'($urandom_range(1, 8)), '0, 0, 1);
            join
        end

        repeat (4) @(posedge clk);
        check("sb_drain", SW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
